// File: rtl/i2c_accel_sequencer.sv
// i2c_accel_sequencer: ADXL345 init writes followed by periodic multi-axis burst reads through an I2C command core
//   clk, rst (async, active-low)
//   core_busy, core_nack, core_rd_valid, core_rd_data : status and read data from the I2C core
//   data_valid, rw, slave_addr, reg_addr, reg_data    : command to the I2C core
//   sample_data, sample_valid                         : axes published together, {MSB, LSB} per axis
//   init_done, overrun, fault                         : status
module i2c_accel_sequencer #(
    parameter int         CLK_HZ          = 50000000,
    parameter int         SAMPLE_HZ       = 100,
    parameter logic [6:0] SLAVE_ADDR      = 7'h1D,
    parameter int         NUM_AXES        = 3,
    parameter logic [7:0] DATA_FORMAT_VAL = 8'h00,
    parameter logic [7:0] POWER_CTL_VAL   = 8'h08,
    parameter int         MAX_RETRY       = 3,
    parameter int         ACCEPT_TIMEOUT  = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    core_busy,
    input  logic                    core_nack,
    input  logic                    core_rd_valid,
    input  logic [7:0]              core_rd_data,
    output logic                    data_valid,
    output logic                    rw,
    output logic [6:0]              slave_addr,
    output logic [7:0]              reg_addr,
    output logic [7:0]              reg_data,
    output logic [16*NUM_AXES-1:0]  sample_data,
    output logic                    sample_valid,
    output logic                    init_done,
    output logic                    overrun,
    output logic                    fault
);
    localparam logic [31:0] P  = 32'(CLK_HZ / SAMPLE_HZ);
    localparam logic [2:0]  NB = 3'(2 * NUM_AXES);
    localparam logic [7:0]  MR = 8'(MAX_RETRY);
    typedef enum logic [2:0] {IDLE, ISSUE, ACCEPT, DONE, WAIT_TICK, PUBLISH, FAULT} state_t;
    typedef enum logic [1:0] {OP_W0, OP_W1, OP_RD} op_t;
    state_t state, state_n;
    op_t op;
    logic [31:0] timer;
    logic [15:0] acc_cnt;
    logic [7:0] retry;
    logic [2:0] b;
    logic [7:0] rd_byte;
    logic rd_got;
    logic [16*NUM_AXES-1:0] shadow;
    logic active, tick, strobe, acc_to, xfer_end, got, ok, fail;
    always_comb begin
        active = state inside {ISSUE, ACCEPT, DONE};
        tick = init_done && timer == P - 32'd1;
        strobe = state == ISSUE && !core_busy;
        acc_to = state == ACCEPT && !core_busy && acc_cnt == 16'(ACCEPT_TIMEOUT - 1);
        // a read byte may arrive in the same cycle busy drops
        got = rd_got || core_rd_valid;
        xfer_end = state == DONE && !core_busy;
        ok = xfer_end && !core_nack && (op != OP_RD || got);
        fail = acc_to || (xfer_end && !ok);
        data_valid = strobe;
        rw = active && op == OP_RD;
        slave_addr = active ? SLAVE_ADDR : 7'h00;
        reg_addr = !active ? 8'h00 : op == OP_W0 ? 8'h31 : op == OP_W1 ? 8'h2D : 8'h32 + {5'd0, b};
        reg_data = !active ? 8'h00 : op == OP_W0 ? DATA_FORMAT_VAL : op == OP_W1 ? POWER_CTL_VAL : 8'h00;
        // ticks landing while a burst or publish is in flight are dropped; a faulted device has no bursts to drop
        overrun = tick && !(state inside {WAIT_TICK, FAULT});
        fault = state == FAULT;
        state_n = state;
        if (fail)
            state_n = retry < MR ? ISSUE : FAULT;
        else if (ok)
            state_n = op == OP_W0 ? ISSUE : op == OP_W1 ? WAIT_TICK : b == NB - 3'd1 ? PUBLISH : ISSUE;
        else
            case (state)
                IDLE:      state_n = ISSUE;
                ISSUE:     state_n = strobe ? ACCEPT : ISSUE;
                ACCEPT:    state_n = core_busy ? DONE : ACCEPT;
                WAIT_TICK: state_n = tick ? ISSUE : WAIT_TICK;
                PUBLISH:   state_n = WAIT_TICK;
                default:   state_n = state;
            endcase
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op <= OP_W0;
            timer <= '0;
            acc_cnt <= '0;
            retry <= '0;
            b <= '0;
            rd_byte <= '0;
            rd_got <= 1'b0;
            shadow <= '0;
            sample_data <= '0;
            sample_valid <= 1'b0;
            init_done <= 1'b0;
        end else begin
            sample_valid <= state == PUBLISH;
            if (state == PUBLISH) sample_data <= shadow;
            if (init_done) timer <= tick ? '0 : timer + 32'd1;
            if (strobe) begin
                acc_cnt <= '0;
                rd_got <= 1'b0;
            end else if (state == ACCEPT) acc_cnt <= acc_cnt + 16'd1;
            if (core_rd_valid && state inside {ACCEPT, DONE}) begin
                rd_got <= 1'b1;
                rd_byte <= core_rd_data;
            end
            if (fail && retry < MR) retry <= retry + 8'd1;
            if (ok) begin
                retry <= '0;
                op <= op == OP_W0 ? OP_W1 : OP_RD;
                if (op == OP_W1) begin
                    init_done <= 1'b1;
                    timer <= '0;
                end
                if (op == OP_RD) begin
                    shadow[8*b +: 8] <= core_rd_valid ? core_rd_data : rd_byte;
                    b <= b + 3'd1;
                end
            end
            if (state == WAIT_TICK && tick) b <= '0;
        end
    end
endmodule
